av_uart_slave: RTL and testbench

AV_UART_SLAVE -- requirements
Module: av_uart_slave

---
 rtl/av_uart_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_av_uart_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/av_uart_slave.sv
// Avalon-MM slave UART: TX FIFO feeding an 8N1 transmitter.
// Define AV_UART_SLAVE_RX_EN to include the receiver path.
module av_uart_slave #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        av_address,
    input  logic        av_write,
    input  logic        av_read,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    output logic        txd,
    input  logic        rxd
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]    BIT_LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_empty, fifo_full, push, pop, flush;
    logic [7:0]       fifo_head;

    tx_state_t        tx_state_reg, tx_state_next;
    logic [CW-1:0]    tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_idx_reg, tx_idx_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             txd_reg, txd_next, tx_bit_done, tx_busy;

    logic             rx_overrun;
    logic [15:0]      rx_word;
    logic [6:0]       count_ext;

    assign fifo_empty     = (count_reg == '0);
    assign fifo_full      = (count_reg == FIFO_FULL_CNT);
    assign av_waitrequest = av_write & ~av_address & fifo_full;
    assign push           = av_write & ~av_address & ~fifo_full;
    assign flush          = av_write & av_address & av_writedata[0];
    assign fifo_head      = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= av_writedata[7:0];
    end

    // A flush re-anchors the read pointer; a same-cycle push survives it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            count_reg  <= CNT_W'(push);
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_idx_reg   <= tx_idx_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end

    assign tx_bit_done = (tx_cnt_reg == BIT_LAST);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_bit_done ? '0 : tx_cnt_reg + CW'(1);
        tx_idx_next   = tx_idx_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        pop           = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next = '0;
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    tx_shift_next = fifo_head;
                    txd_next      = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_state_next = TX_DATA;
                    tx_idx_next   = '0;
                    txd_next      = tx_shift_reg[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    if (tx_idx_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                        txd_next      = 1'b1;
                    end else begin
                        tx_idx_next   = tx_idx_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tx_bit_done) begin
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        tx_shift_next = fifo_head;
                        txd_next      = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign txd     = txd_reg;
    assign tx_busy = (tx_state_reg != TX_IDLE);

`ifdef AV_UART_SLAVE_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_idx_reg, rx_idx_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg, rx_overrun_reg, rx_done, rx_rd_clr, rx_ovr_clr;
    logic          unused_sig;

    assign rx_rd_clr  = av_read & ~av_address;
    assign rx_ovr_clr = av_write & av_address & av_writedata[1];
    assign unused_sig = ^av_writedata[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_reg   <= 1'b1;
            rxd_sync_reg   <= 1'b1;
            rxd_prev_reg   <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_idx_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            rxd_meta_reg <= rxd;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= rxd_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_idx_reg   <= rx_idx_next;
            rx_shift_reg <= rx_shift_next;
            if (rx_done) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_rd_clr) begin
                rx_valid_reg <= 1'b0;
            end
            // A byte still unread when a new one lands is an overrun.
            if (rx_done && rx_valid_reg && !rx_rd_clr)
                rx_overrun_reg <= 1'b1;
            else if (rx_ovr_clr)
                rx_overrun_reg <= 1'b0;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + CW'(1);
        rx_idx_next   = rx_idx_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rxd_prev_reg && !rxd_sync_reg)
                    rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_idx_next   = '0;
                    rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
                    if (rx_idx_reg == 3'd7)
                        rx_state_next = RX_STOP;
                    else
                        rx_idx_next = rx_idx_reg + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_done       = rxd_sync_reg;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_overrun = rx_overrun_reg;
    assign rx_word    = {rx_valid_reg, 7'b0, rx_data_reg};
`else
    logic unused_sig;
    assign unused_sig = ^{av_writedata[15:8], av_writedata[1], av_read, rxd};
    assign rx_overrun = 1'b0;
    assign rx_word    = '0;
`endif

    assign count_ext   = 7'(count_reg);
    assign av_readdata = av_address
        ? {1'b0, count_ext, 4'b0, rx_overrun, tx_busy, fifo_full, fifo_empty}
        : rx_word;

endmodule

// File: tb/tb_av_uart_slave.sv
// Directed bench for av_uart_slave (CLKS_PER_BIT=4, FIFO_DEPTH=4); a txd frame
// decoder collects transmitted bytes and their start cycles.
module tb_av_uart_slave;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n, av_address, av_write, av_read, rxd;
    logic [15:0] av_writedata, av_readdata;
    logic        av_waitrequest, txd;

    always #5 clk = ~clk;

    av_uart_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .av_address(av_address), .av_write(av_write),
        .av_read(av_read), .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .txd(txd), .rxd(rxd)
    );

    typedef struct {
        logic        addr;
        logic        wr;
        logic        rd;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_wait;
        logic        exp_txd;
    } vec_t;

    vec_t vecs [33];
    int   n_vec = 0;
    int   n_err = 0;
    int   stalls;
    bit   accepted;
    int   exp_burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // txd frame decoder: samples mid-bit, records byte (+256 if stop bit bad)
    int         cyc = 0;
    bit         mon_busy = 1'b0;
    int         mon_phase;
    int         mon_start;
    logic [7:0] mon_byte;
    logic       mon_stop;
    int         mon_bytes [$];
    int         mon_starts [$];

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (txd == 1'b0) begin
                mon_busy  = 1'b1;
                mon_phase = 0;
                mon_start = cyc;
            end
        end else begin
            mon_phase++;
            if (mon_phase >= 6 && mon_phase <= 34 && (mon_phase % 4) == 2)
                mon_byte = {txd, mon_byte[7:1]};
            if (mon_phase == 38)
                mon_stop = txd;
            if (mon_phase == 39) begin
                mon_bytes.push_back(mon_stop ? int'(mon_byte) : 256 + int'(mon_byte));
                mon_starts.push_back(mon_start);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic w, input logic r, input logic [15:0] d);
        av_address   = a;
        av_write     = w;
        av_read      = r;
        av_writedata = d;
    endtask

    task automatic apply_vec(input int i);
        @(negedge clk);
        drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
        #1;
        if (vecs[i].rd)
            check($sformatf("v%0d readdata", i), 32'(av_readdata), 32'(vecs[i].exp_rd));
        check($sformatf("v%0d waitrequest", i), 32'(av_waitrequest), 32'(vecs[i].exp_wait));
        check($sformatf("v%0d txd", i), 32'(txd), 32'(vecs[i].exp_txd));
        $display("vec %0d: addr=%0d wr=%0d rd=%0d wdata=0x%04h readdata=0x%04h wait=%0d txd=%0d",
                 i, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, av_readdata,
                 av_waitrequest, txd);
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++)
            apply_vec(i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    task automatic expect_frame(input logic [9:0] pat, input int skip);
        for (int i = skip; i < 40; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            #1;
            check($sformatf("frame sample %0d", i), 32'(txd), 32'(pat[i/4]));
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (mon_bytes.size() < n && k < budget) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            #1;
            k++;
        end
        check("frames seen", 32'(mon_bytes.size()), 32'(n));
    endtask

    task automatic send_rx(input logic [7:0] b);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            rxd = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (CPB) @(negedge clk);
        end
        $display("rx byte driven: 0x%02h", b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // fields: addr, wr, rd, wdata, exp_rd, exp_wait, exp_txd
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h3231, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0100, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'hAB22, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0033, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0055, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0406, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h00A1, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h00A2, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h00A3, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h00A4, 16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h00A5, 16'h0000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0406, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[27] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[28] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0009, 1'b0, 1'b1};
        vecs[29] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h8042, 1'b0, 1'b1};
        vecs[30] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0042, 1'b0, 1'b1};
        vecs[31] = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1};
        vecs[32] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1};

        reset_n = 1'b1;
        rxd     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #2 reset_n = 1'b0;
        #1 check("txd in reset before any clock", 32'(txd), 32'd1);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // Single frame of 0x31: start, LSB-first data, stop
        run_vecs(0, 4);
        expect_frame(10'b1001100010, 1);
        run_vecs(5, 5);

        // Burst of six writes: sixth stalls until the first frame ends
        mon_bytes.delete();
        mon_starts.delete();
        run_vecs(6, 10);
        stalls   = 0;
        accepted = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 16'h0066);
            #1;
            if (av_waitrequest)
                stalls++;
            else
                accepted = 1'b1;
        end
        check("sixth write stall cycles", 32'(stalls), 32'd37);
        check("sixth write accepted", 32'(accepted), 32'd1);
        run_vecs(11, 11);
        wait_frames(6, 300);
        for (int k = 0; k < 6; k++)
            check($sformatf("burst byte %0d", k),
                  32'(k < mon_bytes.size() ? mon_bytes[k] : -1), 32'(exp_burst[k]));
        for (int k = 1; k < 6; k++)
            check($sformatf("burst gap before frame %0d", k),
                  32'(k < mon_starts.size() ? mon_starts[k] - mon_starts[k-1] : -1), 32'd40);
        run_vecs(12, 12);

        // Fill, then flush mid-frame while full
        mon_bytes.delete();
        mon_starts.delete();
        run_vecs(13, 21);
        wait_frames(1, 100);
        idle(60);
        check("frames after flush", 32'(mon_bytes.size()), 32'd1);
        check("flushed-run byte", 32'(mon_bytes.size() > 0 ? mon_bytes[0] : -1), 32'h0A1);
        run_vecs(22, 22);

        // Reset asserted during DATA bit 3
        mon_bytes.delete();
        mon_starts.delete();
        run_vecs(23, 25);
        idle(16);
        @(negedge clk);
        #1 check("txd at data bit 3", 32'(txd), 32'd0);
        #1 reset_n = 1'b0;
        #1 check("txd async high on reset", 32'(txd), 32'd1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        run_vecs(26, 26);
        idle(60);
        check("frames after mid-frame reset", 32'(mon_bytes.size()), 32'd0);
        run_vecs(27, 27);

`ifdef AV_UART_SLAVE_RX_EN
        send_rx(8'h41);
        send_rx(8'h42);
        idle(8);
        run_vecs(28, 32);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
